param_data_mem: RTL and testbench
=================================

PARAM_DATA_MEM -- requirements
Module: param_data_mem

Interface
REQ-001 Parameter DATA_WIDTH, default 16, word width in bits; multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 10, address port width.
REQ-003 Parameter DEPTH, default 1024, number of words; DEPTH <= 2**ADDR_WIDTH.
REQ-004 Parameter LATENCY, default 4, access wait cycles; LATENCY >= 1.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 mem_read  input  1  read request strobe.
REQ-008 mem_write  input  1  write request strobe.
REQ-009 addr  input  ADDR_WIDTH  word address.
REQ-010 write_data  input  DATA_WIDTH  write word.
REQ-011 byte_en  input  DATA_WIDTH/8  per-byte write enable; bit i covers bits 8i+7..8i.
REQ-012 read_data  output  DATA_WIDTH  read result; holds last completed read.
REQ-013 busy  output  1  access in progress; new requests ignored.
REQ-014 read_valid  output  1  one-cycle pulse: read_data updated this cycle.
REQ-015 done  output  1  one-cycle pulse: access (read or write) completed.
REQ-016 addr_err  output  1  one-cycle pulse with done: address >= DEPTH.

Function
REQ-017 States: IDLE, WAIT, DONE; request accepted at a rising edge when state is IDLE or DONE and mem_read or mem_write is high.
REQ-018 On acceptance: latch addr, write_data, byte_en, operation; load wait counter with LATENCY-1; go to WAIT.
REQ-019 mem_read and mem_write both high at acceptance: write performed, read dropped, no read_valid.
REQ-020 WAIT: busy = 1; counter decrements each cycle; at edge with counter = 0, perform access, go to DONE.
REQ-021 Request accepted at edge ending cycle T: busy high cycles T+1..T+LATENCY; done high in cycle T+LATENCY+1.
REQ-022 DONE: busy = 0, done = 1 for exactly one cycle; read_valid = 1 only for reads; next state WAIT if new request accepted, else IDLE.
REQ-023 Sustained throughput: one access per LATENCY+1 cycles.
REQ-024 Requests presented while busy = 1 are ignored, not queued.
REQ-025 Write: for each byte_en bit set, corresponding byte of word[addr] replaced; byte_en all zero leaves memory unchanged but still produces done.
REQ-026 Read: read_data = word[latched addr] in DONE cycle; unchanged otherwise.
REQ-027 Latched addr >= DEPTH: no memory access; addr_err = 1 with done; a read returns read_data = 0 with read_valid = 1.
REQ-028 Write then read of same address in back-to-back accesses returns the new data.

Reset
REQ-029 reset_n low: state IDLE, counter 0, busy 0, done 0, read_valid 0, addr_err 0, read_data 0, asynchronously.
REQ-030 Reset during WAIT aborts the access; a pending write is not performed.
REQ-031 Memory array contents are not reset.

Structure
REQ-032 Package param_data_mem_pkg holds the state enum (IDLE, WAIT, DONE) and default parameter constants.
REQ-033 One sub-module mem_array: DEPTH x DATA_WIDTH storage, byte-enabled synchronous write, synchronous read, no reset.
REQ-034 FSM, counter and output registers reside in param_data_mem.

Verification
REQ-035 Defaults; write 0xBEEF to addr 5, byte_en 2'b11; read addr 5 -> done at T+5, read_valid with read_data 0xBEEF, busy high 4 cycles.
REQ-036 Write 0x1234 to addr 7, then byte_en 2'b10 write 0xAB00 -> read addr 7 returns 0xAB34.
REQ-037 DEPTH = 1000; read addr 1010 -> addr_err and read_valid pulse, read_data 0x0000; write addr 1010 -> addr_err, no array change.
REQ-038 Read request held high while busy -> exactly one access per 5 cycles, no extra done pulses.
REQ-039 Write 0x5555 to addr 3 (LATENCY 4); assert reset_n low in second WAIT cycle -> all outputs 0, later read of addr 3 returns prior contents.
REQ-040 mem_read and mem_write high together, write_data 0x00FF addr 2 -> done without read_valid; read addr 2 returns 0x00FF.

Source files
------------

// File: rtl/param_data_mem_pkg.sv
// -----------------------------------------------------------------------------
// param_data_mem_pkg
// Shared definitions for the fixed-latency data memory:
//   - default parameter values used by param_data_mem and mem_array
//   - access FSM state encoding
//   - a helper that sizes the wait counter for a given latency
// -----------------------------------------------------------------------------
package param_data_mem_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DEPTH      = 1024;
    localparam int DEF_LATENCY    = 4;

    // Access FSM: idle, counting down the access latency, completion cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The counter only has to hold LATENCY-1; it never goes below one bit.
    function automatic int cnt_width(input int latency);
        if (latency > 1) begin
            return $clog2(latency);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/param_data_mem_mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// DEPTH x DATA_WIDTH word storage with a byte-enabled synchronous write port
// and a registered synchronous read port. The storage is never reset.
// Reads of addresses at or beyond DEPTH return zero; writes there are dropped.
//
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write word address
//   wr_data  in   write word
//   wr_be    in   per-byte write enable (bit i -> bits 8i+7..8i)
//   rd_addr  in   read word address (sampled every rising edge)
//   rd_data  out  registered read word
// -----------------------------------------------------------------------------
module mem_array
    import param_data_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    localparam int                  BE_W    = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic                  wr_in_range_s;
    logic                  rd_in_range_s;

    assign wr_in_range_s = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_in_range_s = ({1'b0, rd_addr} < DEPTH_L);
    assign rd_data       = rd_data_r;

    // Byte-enabled write of the addressed word.
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range_s) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be[i]) begin
                    mem_r[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Registered read; out-of-range addresses never index the array.
    always_ff @(posedge clk) begin
        if (rd_in_range_s) begin
            rd_data_r <= mem_r[rd_addr];
        end else begin
            rd_data_r <= {DATA_WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/param_data_mem.sv
// -----------------------------------------------------------------------------
// param_data_mem
// Single-port data memory with a fixed, parameterised access latency.
// A request is accepted in IDLE or DONE; the FSM then stays in WAIT for
// LATENCY cycles (busy high), performs the access on the last WAIT edge and
// spends one DONE cycle pulsing done (plus read_valid for reads, addr_err for
// out-of-range addresses). Requests seen while busy are dropped.
//
// Ports:
//   clk         in   clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   mem_read    in   read request strobe
//   mem_write   in   write request strobe (wins over mem_read)
//   addr        in   word address
//   write_data  in   write word
//   byte_en     in   per-byte write enable
//   read_data   out  last completed read result
//   busy        out  access in progress
//   read_valid  out  read_data updated this cycle
//   done        out  access completed this cycle
//   addr_err    out  completed access was out of range
// -----------------------------------------------------------------------------
module param_data_mem
    import param_data_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    busy,
    output logic                    read_valid,
    output logic                    done,
    output logic                    addr_err
);

    localparam int                  BE_W     = DATA_WIDTH / 8;
    localparam int                  CNT_W    = cnt_width(LATENCY);
    localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);

    state_e                  state_r;
    state_e                  state_nxt_s;
    logic [CNT_W-1:0]        cnt_r;
    logic                    is_write_r;
    logic                    is_read_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [BE_W-1:0]         be_r;

    logic                    busy_r;
    logic                    done_r;
    logic                    read_valid_r;
    logic                    addr_err_r;
    logic [DATA_WIDTH-1:0]   read_data_r;

    logic                    accept_s;
    logic                    access_s;
    logic                    addr_ok_s;
    logic                    mem_we_s;
    logic [ADDR_WIDTH-1:0]   rd_addr_s;
    logic [DATA_WIDTH-1:0]   rd_q_s;

    assign accept_s  = ((state_r == ST_IDLE) || (state_r == ST_DONE)) &&
                       (mem_read || mem_write);
    assign access_s  = (state_r == ST_WAIT) && (cnt_r == {CNT_W{1'b0}});
    assign addr_ok_s = ({1'b0, addr_r} < DEPTH_L);
    assign mem_we_s  = access_s && is_write_r && addr_ok_s;

    // The array read port follows the incoming address on the accept edge so
    // that even with LATENCY = 1 the word is already registered by the time
    // the access edge copies it into read_data.
    assign rd_addr_s = accept_s ? addr : addr_r;

    assign read_data  = read_data_r;
    assign busy       = busy_r;
    assign read_valid = read_valid_r;
    assign done       = done_r;
    assign addr_err   = addr_err_r;

    mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem_array (
        .clk     (clk),
        .wr_en   (mem_we_s),
        .wr_addr (addr_r),
        .wr_data (wdata_r),
        .wr_be   (be_r),
        .rd_addr (rd_addr_s),
        .rd_data (rd_q_s)
    );

    // Next-state decode for the access FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (accept_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Latency counter: loaded on accept, counts down while waiting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            cnt_r <= CNT_LOAD;
        end else if ((state_r == ST_WAIT) && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Request capture; a simultaneous read and write becomes a write only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            is_write_r <= 1'b0;
            is_read_r  <= 1'b0;
            addr_r     <= {ADDR_WIDTH{1'b0}};
            wdata_r    <= {DATA_WIDTH{1'b0}};
            be_r       <= {BE_W{1'b0}};
        end else if (accept_s) begin
            is_write_r <= mem_write;
            is_read_r  <= mem_read && !mem_write;
            addr_r     <= addr;
            wdata_r    <= write_data;
            be_r       <= byte_en;
        end else begin
            is_write_r <= is_write_r;
            is_read_r  <= is_read_r;
            addr_r     <= addr_r;
            wdata_r    <= wdata_r;
            be_r       <= be_r;
        end
    end

    // Status outputs, registered so they line up with the FSM state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            read_valid_r <= 1'b0;
            addr_err_r   <= 1'b0;
        end else begin
            busy_r       <= (state_nxt_s == ST_WAIT);
            done_r       <= access_s;
            read_valid_r <= access_s && is_read_r;
            addr_err_r   <= access_s && !addr_ok_s;
        end
    end

    // Read result register: updated only when a read completes, else held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data_r <= {DATA_WIDTH{1'b0}};
        end else if (access_s && is_read_r) begin
            if (addr_ok_s) begin
                read_data_r <= rd_q_s;
            end else begin
                read_data_r <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            read_data_r <= read_data_r;
        end
    end

endmodule

// File: tb/tb_param_data_mem.sv
// -----------------------------------------------------------------------------
// tb_param_data_mem
// Self-checking bench for param_data_mem (DEPTH = 1000, other parameters at
// their defaults). Each tracked request pushes its expected completion onto a
// queue; a monitor pops and compares on every done pulse. Request tasks also
// measure completion latency and busy duration.
// -----------------------------------------------------------------------------
module tb_param_data_mem;

    localparam int DW      = 16;
    localparam int AW      = 10;
    localparam int DEPTH   = 1000;
    localparam int LATENCY = 4;

    typedef struct packed {
        logic          rv;
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] addr;
    logic [DW-1:0] write_data;
    logic [1:0]    byte_en;
    logic [DW-1:0] read_data;
    logic          busy;
    logic          read_valid;
    logic          done;
    logic          addr_err;

    int            n_checks = 0;
    int            n_errors = 0;
    int            done_cnt = 0;
    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] model_mem [0:1023];
    logic [DW-1:0] last_rd;

    always #5 clk = ~clk;

    param_data_mem #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .LATENCY    (LATENCY)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .write_data (write_data),
        .byte_en    (byte_en),
        .read_data  (read_data),
        .busy       (busy),
        .read_valid (read_valid),
        .done       (done),
        .addr_err   (addr_err)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Compute the expected completion of a request and update the model.
    task automatic push_exp(input logic rd, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [1:0] be);
        exp_t e;
        e.err  = (a >= 10'd1000);
        e.rv   = rd & ~wr;
        e.data = e.err ? 16'h0000 : model_mem[a];
        if (wr && !e.err) begin
            if (be[0]) model_mem[a][7:0]  = wd[7:0];
            if (be[1]) model_mem[a][15:8] = wd[15:8];
        end
        exp_q.push_back(e);
    endtask

    // Issue one tracked request (called away from the rising edge, with the
    // DUT in IDLE or DONE) and wait for its completion pulse.
    task automatic run_access(input logic rd, input logic wr, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input logic [1:0] be);
        int lat;
        int bcnt;
        lat  = 0;
        bcnt = 0;
        push_exp(rd, wr, a, wd, be);
        mem_read   = rd;
        mem_write  = wr;
        addr       = a;
        write_data = wd;
        byte_en    = be;
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
        check_val("done_latency", lat, LATENCY + 1);
        check_val("busy_cycles", bcnt, LATENCY);
    endtask

    // Scoreboard: every done pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset_n) begin
            check_val("pulse_without_done", {31'b0, (read_valid | addr_err) & ~done}, 32'd0);
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check_val("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("read_valid", {31'b0, read_valid}, {31'b0, mon_e.rv});
                    check_val("addr_err", {31'b0, addr_err}, {31'b0, mon_e.err});
                    if (mon_e.rv) begin
                        check_val("read_data", {16'b0, read_data}, {16'b0, mon_e.data});
                        last_rd = mon_e.data;
                    end else begin
                        check_val("read_data_hold", {16'b0, read_data}, {16'b0, last_rd});
                    end
                end
            end
        end
    end

    initial begin
        int snap;
        reset_n    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        addr       = 10'd0;
        write_data = 16'h0000;
        byte_en    = 2'b00;
        last_rd    = 16'h0000;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_busy", {31'b0, busy}, 32'd0);
        check_val("rst_done", {31'b0, done}, 32'd0);
        check_val("rst_read_valid", {31'b0, read_valid}, 32'd0);
        check_val("rst_addr_err", {31'b0, addr_err}, 32'd0);
        check_val("rst_read_data", {16'b0, read_data}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic write/read
        run_access(1'b0, 1'b1, 10'd5, 16'hBEEF, 2'b11);
        run_access(1'b1, 1'b0, 10'd5, 16'h0000, 2'b00);

        // Byte-enabled overwrite, then back-to-back read of the same word
        run_access(1'b0, 1'b1, 10'd7, 16'h1234, 2'b11);
        run_access(1'b0, 1'b1, 10'd7, 16'hAB00, 2'b10);
        run_access(1'b1, 1'b0, 10'd7, 16'h0000, 2'b00);

        // Out-of-range read and write
        run_access(1'b1, 1'b0, 10'd1010, 16'h0000, 2'b00);
        run_access(1'b0, 1'b1, 10'd1010, 16'hDEAD, 2'b11);
        run_access(1'b1, 1'b0, 10'd7, 16'h0000, 2'b00);
        run_access(1'b1, 1'b0, 10'd999, 16'h0000, 2'b00);

        // All-zero byte enable leaves the word alone
        run_access(1'b0, 1'b1, 10'd5, 16'hFFFF, 2'b00);
        run_access(1'b1, 1'b0, 10'd5, 16'h0000, 2'b00);

        // Read held high for 20 edges: accepted on edges 0, 5, 10, 15 only
        #1;
        snap = done_cnt;
        for (int i = 0; i < 4; i++) push_exp(1'b1, 1'b0, 10'd5, 16'h0000, 2'b00);
        mem_read = 1'b1;
        addr     = 10'd5;
        repeat (20) @(posedge clk);
        #1;
        mem_read = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_val("held_read_done_count", done_cnt - snap, 32'd4);
        check_val("held_read_queue_empty", exp_q.size(), 32'd0);
        @(negedge clk);

        // Read and write together: the write wins
        run_access(1'b1, 1'b1, 10'd2, 16'h00FF, 2'b11);
        run_access(1'b1, 1'b0, 10'd2, 16'h0000, 2'b00);

        // Reset during WAIT aborts a pending write
        run_access(1'b0, 1'b1, 10'd3, 16'h1111, 2'b11);
        @(negedge clk);
        mem_write  = 1'b1;
        addr       = 10'd3;
        write_data = 16'h5555;
        byte_en    = 2'b11;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
        check_val("wait2_busy", {31'b0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_val("abort_busy", {31'b0, busy}, 32'd0);
        check_val("abort_done", {31'b0, done}, 32'd0);
        check_val("abort_read_valid", {31'b0, read_valid}, 32'd0);
        check_val("abort_addr_err", {31'b0, addr_err}, 32'd0);
        check_val("abort_read_data", {16'b0, read_data}, 32'd0);
        last_rd = 16'h0000;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        run_access(1'b1, 1'b0, 10'd3, 16'h0000, 2'b00);

        repeat (8) @(negedge clk);
        check_val("final_queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
